// File: rtl/prog_loader.sv
// Boot-time program loader: takes a byte stream (N_lo, N_hi, N*B data bytes, XOR checksum),
// writes little-endian words to consecutive ram addresses, then raises cpu_run or err.
module prog_loader #(
  parameter int                   ADR_WIDTH  = 16,
  parameter logic [ADR_WIDTH-1:0] BASE_ADR   = '0,
  parameter int                   DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADR_WIDTH-1:0]  mem_adr,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_writeEn,
  output logic                  cpu_run,
  output logic                  err
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t                state;
  logic [15:0]           word_cnt;
  logic [15:0]           word_idx;
  logic [BW-1:0]         byte_idx;
  logic [7:0]            csum;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  xfer;

  // Handshake: a byte moves when in_valid && in_ready; in_ready depends only on
  // state and rst, so every receive state accepts each valid byte without stalling.
  assign in_ready = !rst && (state != DONE) && (state != ERROR);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    next_word = asm_word;
    next_word[{byte_idx, 3'b000} +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR_LO;
      word_cnt      <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      csum          <= '0;
      asm_word      <= '0;
      mem_adr       <= BASE_ADR;
      mem_writeData <= '0;
      mem_writeEn   <= 1'b0;
      cpu_run       <= 1'b0;
      err           <= 1'b0;
    end else begin
      mem_writeEn <= 1'b0;
      if (xfer) begin
        case (state)
          HDR_LO: begin
            word_cnt[7:0] <= in_data;
            state         <= HDR_HI;
          end
          HDR_HI: begin
            word_cnt[15:8] <= in_data;
            state          <= ({in_data, word_cnt[7:0]} == 16'd0) ? CSUM : DATA;
          end
          DATA: begin
            csum <= csum ^ in_data;
            if (byte_idx == BW'(B - 1)) begin
              // The completed word goes straight to the output register, so the
              // assembly register is free for the next word's first byte.
              mem_writeEn   <= 1'b1;
              mem_adr       <= BASE_ADR + ADR_WIDTH'(word_idx);
              mem_writeData <= next_word;
              word_idx      <= word_idx + 16'd1;
              byte_idx      <= '0;
              if (word_idx + 16'd1 == word_cnt) state <= CSUM;
            end else begin
              asm_word <= next_word;
              byte_idx <= byte_idx + BW'(1);
            end
          end
          CSUM: begin
            if (in_data == csum) begin
              state   <= DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= ERROR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 0x0000 and 0xFFFF) share one byte stream;
// a word-level model fills per-instance expected write queues and predicts the final flags.
module tb_prog_loader;

  localparam int EW = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;

  logic        in_ready0, in_ready1;
  logic [15:0] adr0, adr1;
  logic [63:0] wd0, wd1;
  logic        we0, we1, run0, run1, err0, err1;

  int n_total = 0;
  int n_pass  = 0;
  int gap_pct = 0;
  int gap_after_word = 0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  prog_loader #(.ADR_WIDTH(16), .BASE_ADR(16'h0000), .DATA_WIDTH(64)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .mem_adr(adr0), .mem_writeData(wd0), .mem_writeEn(we0), .cpu_run(run0), .err(err0)
  );

  prog_loader #(.ADR_WIDTH(16), .BASE_ADR(16'hFFFF), .DATA_WIDTH(64)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .mem_adr(adr1), .mem_writeData(wd1), .mem_writeEn(we1), .cpu_run(run1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: every write strobe is matched against the head of its expected queue.
  logic prev_we0 = 1'b0;
  logic prev_we1 = 1'b0;
  always @(negedge clk) begin
    if (we0) begin
      if (exp_q0.size() == 0) check("wr0_unexpected", EW'(we0), '0);
      else check("wr0", {adr0, wd0}, exp_q0.pop_front());
    end
    if (we1) begin
      if (exp_q1.size() == 0) check("wr1_unexpected", EW'(we1), '0);
      else check("wr1", {adr1, wd1}, exp_q1.pop_front());
    end
    if (prev_we0) check("we0_pulse", EW'(we0), '0);
    if (prev_we1) check("we1_pulse", EW'(we1), '0);
    prev_we0 = we0;
    prev_we1 = we1;
  end

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", EW'({in_ready0, in_ready1}), '0);
    check("rst_adr0", EW'(adr0), EW'(16'h0000));
    check("rst_adr1", EW'(adr1), EW'(16'hFFFF));
    check("rst_wdata", EW'(wd0 | wd1), '0);
    check("rst_flags", EW'({we0, we1, run0, run1, err0, err1}), '0);
    rst = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    check("in_ready", EW'({in_ready0, in_ready1}), EW'(2'b11));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Model: words are the data bytes taken B at a time, least significant first;
  // the run succeeds iff the trailing byte equals the XOR of all data bytes.
  task automatic run_prog(input int n, input logic [7:0] data[$], input logic [7:0] cs);
    logic [7:0]  x;
    logic [63:0] word;
    logic        good;
    x = 8'h00;
    for (int i = 0; i < data.size(); i++) x = x ^ data[i];
    good = (x == cs);
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int k = 0; k < 8; k++) word = word | (64'(data[w*8+k]) << (8*k));
      exp_q0.push_back({16'(w), word});
      exp_q1.push_back({16'hFFFF + 16'(w), word});
    end
    send_byte(8'(n));
    send_byte(8'(n >> 8));
    for (int i = 0; i < data.size(); i++) begin
      send_byte(data[i]);
      if (gap_after_word != 0 && (i % 8) == 7) idle_cycle();
    end
    check("flags_before_csum", EW'({run0, run1, err0, err1}), '0);
    send_byte(cs);
    check("run_after_csum", EW'({run0, run1}), good ? EW'(2'b11) : '0);
    check("err_after_csum", EW'({err0, err1}), good ? '0 : EW'(2'b11));
    check("writes_drained", EW'(exp_q0.size() + exp_q1.size()), '0);
    // Extra bytes after the checksum must be refused and leave the flags alone.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom_range(255));
      check("ready_low_after", EW'({in_ready0, in_ready1}), '0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("sticky_flags", EW'({run0, run1, err0, err1}), good ? EW'(4'b1100) : EW'(4'b0011));
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] x;
    int n;

    apply_reset();

    // Single word, good checksum.
    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_prog(1, d, 8'h08);

    // Empty program: good and bad checksum.
    apply_reset();
    d = {};
    run_prog(0, d, 8'h00);
    apply_reset();
    run_prog(0, d, 8'h55);

    // Bad checksum with data: write still happens.
    apply_reset();
    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_prog(1, d, 8'h09);

    // Two words with random idles and a forced idle after each word's last byte.
    apply_reset();
    gap_pct = 50;
    gap_after_word = 1;
    d = {};
    x = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d.push_back(8'($urandom_range(255)));
      x = x ^ d[i];
    end
    run_prog(2, d, x);
    gap_pct = 0;
    gap_after_word = 0;

    // Reset mid-word: the partial word must never be written.
    apply_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(255)));
    apply_reset();
    d = {};
    for (int i = 0; i < 8; i++) d.push_back(8'h11);
    run_prog(1, d, 8'h00);

    // Reset asserted in the cycle the last byte of a word is offered: no write.
    apply_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(255)));
    in_valid = 1'b1;
    in_data  = 8'hA5;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check("we_suppressed", EW'({we0, we1}), '0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    d = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_prog(1, d, 8'h00);

    // Random programs with random idle density and occasional bad checksums.
    for (int t = 0; t < 8; t++) begin
      apply_reset();
      gap_pct = $urandom_range(0, 60);
      n = $urandom_range(0, 4);
      d = {};
      x = 8'h00;
      for (int i = 0; i < n * 8; i++) begin
        d.push_back(8'($urandom_range(255)));
        x = x ^ d[i];
      end
      if ($urandom_range(3) == 0) x = x ^ 8'($urandom_range(1, 255));
      run_prog(n, d, x);
    end
    gap_pct = 0;

    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
